// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control-unit <-> datapath signal bundle
interface mips_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               pcen;
    logic               memwrite;
    logic               irwrite;
    logic               regwrite;
    logic               iord;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic               memtoreg;
    logic               regdst;
    logic [2:0]         alucontrol;
    logic               illegal_op;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
               pcsrc, memtoreg, regdst, alucontrol, illegal_op, state_o
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
               pcsrc, memtoreg, regdst, alucontrol, illegal_op, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control unit (main FSM, ALU decoder, PC enable)
module mips_multicycle_ctrl #(
    parameter int         STATE_W  = 4,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_ctrl_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = FETCH;
        pcwrite        = 1'b0;
        branch         = 1'b0;
        aluop          = 2'b00;
        irwrite_raw    = 1'b0;
        regwrite_raw   = 1'b0;
        memwrite_raw   = 1'b0;
        bus.iord       = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.memtoreg   = 1'b0;
        bus.regdst     = 1'b0;
        bus.illegal_op = 1'b0;

        case (state)
            FETCH: begin
                bus.alusrcb = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                state_nxt   = DECODE;
            end
            DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXEC;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_ADDI:      state_nxt = ADDIEX;
                    OP_J:         state_nxt = JUMP;
                    default: begin
                        // Unsupported opcodes retire as a nop straight back to FETCH.
                        state_nxt      = FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_nxt   = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.iord  = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXEC: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b10;
                state_nxt   = ALUWB;
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                regwrite_raw = 1'b1;
            end
            BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b01;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_nxt   = ADDIWB;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_comb begin
        bus.alucontrol = 3'b010;
        case (aluop)
            2'b00: bus.alucontrol = 3'b010;
            2'b01: bus.alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: bus.alucontrol = 3'b010;
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end

    // Reset parks the FSM in FETCH, whose write enables must still stay quiet while reset is held.
    assign bus.pcen     = reset & (pcwrite | (branch & bus.zero));
    assign bus.irwrite  = reset & irwrite_raw;
    assign bus.regwrite = reset & regwrite_raw;
    assign bus.memwrite = reset & memwrite_raw;
    assign bus.state_o  = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    mips_multicycle_ctrl_if #(.STATE_W(4)) bus ();

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {state, pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb, pcsrc, memtoreg, regdst, alucontrol, illegal_op}
    logic [19:0] obs;
    assign obs = {bus.state_o, bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                  bus.iord, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.memtoreg,
                  bus.regdst, bus.alucontrol, bus.illegal_op};

    function automatic logic [19:0] pk(input int st, input bit pcen, input bit mw, input bit irw,
                                       input bit rw, input bit iord, input bit asa, input int asb,
                                       input int pcs, input bit m2r, input bit rd, input int alu,
                                       input bit ill);
        return {st[3:0], pcen, mw, irw, rw, iord, asa, asb[1:0], pcs[1:0], m2r, rd, alu[2:0], ill};
    endfunction

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [19:0] v_fetch, v_decode, v_held, v_memadr, v_memrd, v_memwb, v_memwr;
    logic [19:0] v_aluwb, v_addiex, v_addiwb, v_jump, v_illdec;

    logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    int         alus   [6] = '{2, 6, 0, 1, 7, 2};

    initial begin
        v_held   = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0);
        v_fetch  = pk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2, 0);
        v_decode = pk(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 2, 0);
        v_illdec = pk(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 2, 1);
        v_memadr = pk(2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 2, 0);
        v_memrd  = pk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0);
        v_memwb  = pk(4, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 0);
        v_memwr  = pk(5, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0);
        v_aluwb  = pk(7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0);
        v_addiex = pk(9, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 2, 0);
        v_addiwb = pk(10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0);
        v_jump   = pk(11, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0);

        reset     = 1'b0;
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;

        tick();
        check("reset_held_1", obs, v_held);
        tick();
        check("reset_held_2", obs, v_held);
        reset = 1'b1;
        #1;
        check("first_fetch", obs, v_fetch);

        bus.op = 6'b100011;
        tick(); check("lw_decode", obs, v_decode);
        tick(); check("lw_memadr", obs, v_memadr);
        tick(); check("lw_memrd", obs, v_memrd);
        tick(); check("lw_memwb", obs, v_memwb);
        tick(); check("lw_fetch", obs, v_fetch);

        bus.op = 6'b101011;
        tick(); check("sw_decode", obs, v_decode);
        tick(); check("sw_memadr", obs, v_memadr);
        tick(); check("sw_memwr", obs, v_memwr);
        tick(); check("sw_fetch", obs, v_fetch);

        for (int i = 0; i < 6; i++) begin
            bus.op    = 6'b000000;
            bus.funct = functs[i];
            bus.zero  = 1'b1;
            tick(); check($sformatf("r%0d_decode", i), obs, v_decode);
            tick(); check($sformatf("r%0d_exec", i), obs, pk(6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, alus[i], 0));
            tick(); check($sformatf("r%0d_aluwb", i), obs, v_aluwb);
            tick(); check($sformatf("r%0d_fetch", i), obs, v_fetch);
        end

        for (int z = 1; z >= 0; z--) begin
            bus.op   = 6'b000100;
            bus.zero = z[0];
            tick(); check($sformatf("beq_z%0d_decode", z), obs, v_decode);
            tick(); check($sformatf("beq_z%0d_branch", z), obs, pk(8, z[0], 0, 0, 0, 0, 1, 0, 1, 0, 0, 6, 0));
            tick(); check($sformatf("beq_z%0d_fetch", z), obs, v_fetch);
        end

        bus.op = 6'b001000;
        tick(); check("addi_decode", obs, v_decode);
        tick(); check("addi_ex", obs, v_addiex);
        tick(); check("addi_wb", obs, v_addiwb);
        tick(); check("addi_fetch", obs, v_fetch);

        bus.op = 6'b000010;
        tick(); check("j_decode", obs, v_decode);
        tick(); check("j_jump", obs, v_jump);
        tick(); check("j_fetch", obs, v_fetch);

        bus.op = 6'b111111;
        tick(); check("ill_decode", obs, v_illdec);
        tick(); check("ill_fetch", obs, v_fetch);

        bus.op = 6'b100011;
        tick(); check("abort_decode", obs, v_decode);
        tick(); check("abort_memadr", obs, v_memadr);
        tick(); check("abort_memrd", obs, v_memrd);
        reset = 1'b0;
        #1;
        check("abort_async", obs, v_held);
        tick(); check("abort_held", obs, v_held);
        reset = 1'b1;
        #1;
        check("abort_refetch", obs, v_fetch);
        tick(); check("abort_redecode", obs, v_decode);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
